mux_shift_reg: RTL and testbench

Parameterised universal shift register that consumes the output of the 2:1 selection stage. Each register bit is fed through a mode-select mux: hold, shift right, shift left or parallel load. A shift counter and a DONE flag mark when a loaded word has been fully serialised. The block is the first sequential stage downstream of the mux cell and serves as the lab's serialiser/deserialiser.

---
 rtl/mux_shift_reg.sv | 80 ++++++++
 tb/tb_mux_shift_reg.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mux_shift_reg.sv
// Universal shift register (hold / shift right / shift left / load) with a saturating
// shift counter and DONE flag, used as the lab's serialiser/deserialiser.

module mux2 (
    input  logic a,
    input  logic b,
    input  logic sel,
    output logic y
);
    assign y = sel ? b : a;
endmodule

module mux_shift_reg #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] D,
    input  logic             SIN_R,
    input  logic             SIN_L,
    output logic [WIDTH-1:0] Q,
    output logic             SOUT_R,
    output logic             SOUT_L,
    output logic [CW-1:0]    CNT,
    output logic             DONE
);
    localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

    logic [WIDTH-1:0] shr_vec;
    logic [WIDTH-1:0] shl_vec;
    logic [WIDTH-1:0] lvl_a;
    logic [WIDTH-1:0] lvl_b;
    logic [WIDTH-1:0] q_next;
    logic [CW-1:0]    cnt_next;
    logic             done_next;
    logic             shifting;

    assign shr_vec = {SIN_R, Q[WIDTH-1:1]};
    assign shl_vec = {Q[WIDTH-2:0], SIN_L};

    // MODE[0] picks within {hold, shr} and {shl, load}; MODE[1] picks between the pairs.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        mux2 u_lo  (.a(Q[i]),       .b(shr_vec[i]), .sel(MODE[0]), .y(lvl_a[i]));
        mux2 u_hi  (.a(shl_vec[i]), .b(D[i]),       .sel(MODE[0]), .y(lvl_b[i]));
        mux2 u_out (.a(lvl_a[i]),   .b(lvl_b[i]),   .sel(MODE[1]), .y(q_next[i]));
    end

    assign shifting = MODE[0] ^ MODE[1];

    always_comb begin
        // NOTE: default every comb output first so no path leaves it unassigned (no latch).
        cnt_next = CNT;
        if (MODE == 2'b11) begin
            cnt_next = '0;
        end else if (shifting && (CNT != CNT_FULL)) begin
            cnt_next = CNT + CW'(1);
        end
    end

    assign done_next = (cnt_next == CNT_FULL);

    always_ff @(posedge CLK) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (RST) begin
            Q    <= '0;
            CNT  <= '0;
            DONE <= 1'b0;
        end else if (EN) begin
            Q    <= q_next;
            CNT  <= cnt_next;
            DONE <= done_next;
        end
    end

    assign SOUT_R = Q[0];
    assign SOUT_L = Q[WIDTH-1];
endmodule

// File: tb/tb_mux_shift_reg.sv
// Directed bench for mux_shift_reg: a behavioural model checked every cycle plus
// hand-computed literal expectations for each scenario.

module tb_mux_shift_reg;
    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk;
    logic          rst;
    logic          en;
    logic [1:0]    mode;
    logic [W-1:0]  d;
    logic          sin_r;
    logic          sin_l;
    logic [W-1:0]  q;
    logic          sout_r;
    logic          sout_l;
    logic [CW-1:0] cnt;
    logic          done;

    int checks   = 0;
    int failures = 0;

    int mdl_q     = 0;
    int mdl_cnt   = 0;
    bit mdl_valid = 0;

    mux_shift_reg #(.WIDTH(W)) dut (
        .CLK(clk), .RST(rst), .EN(en), .MODE(mode), .D(d),
        .SIN_R(sin_r), .SIN_L(sin_l), .Q(q), .SOUT_R(sout_r),
        .SOUT_L(sout_l), .CNT(cnt), .DONE(done)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: register value as an integer, counter as a plain saturating count.
    always @(posedge clk) begin
        if (rst) begin
            mdl_q     = 0;
            mdl_cnt   = 0;
            mdl_valid = 1;
        end else if (en && mdl_valid) begin
            case (mode)
                2'b01: begin
                    mdl_q   = (mdl_q >> 1) + (int'(sin_r) * (1 << (W - 1)));
                    mdl_cnt = (mdl_cnt < W) ? mdl_cnt + 1 : W;
                end
                2'b10: begin
                    mdl_q   = ((mdl_q * 2) % (1 << W)) + int'(sin_l);
                    mdl_cnt = (mdl_cnt < W) ? mdl_cnt + 1 : W;
                end
                2'b11: begin
                    mdl_q   = int'(d);
                    mdl_cnt = 0;
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mdl_valid) begin
            check("model_q",    32'(q),      32'(mdl_q));
            check("model_cnt",  32'(cnt),    32'(mdl_cnt));
            check("model_done", 32'(done),   32'(mdl_cnt == W));
            check("model_sr",   32'(sout_r), 32'(mdl_q % 2));
            check("model_sl",   32'(sout_l), 32'(mdl_q >> (W - 1)));
        end
    end

    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [W-1:0] dv, input logic sr, input logic sl);
        @(negedge clk);
        #2;
        rst = r; en = e; mode = m; d = dv; sin_r = sr; sin_l = sl;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic [W-1:0] eq,
                               input int ec, input logic ed);
        check({tag, "_q"},    32'(q),    32'(eq));
        check({tag, "_cnt"},  32'(cnt),  32'(ec));
        check({tag, "_done"}, 32'(done), 32'(ed));
    endtask

    initial begin
        logic [7:0] sr_bits;
        logic [7:0] sl_bits;
        sr_bits = 8'b1010_0101;
        sl_bits = 8'b1100_1011;
        rst = 1'b0; en = 1'b0; mode = 2'b00; d = '0; sin_r = 1'b0; sin_l = 1'b0;

        // Reset dominates a pending load
        step(1, 1, 2'b11, 8'hFF, 0, 0);
        step(1, 1, 2'b11, 8'hFF, 0, 0);
        check_state("reset", 8'h00, 0, 1'b0);
        step(0, 1, 2'b11, 8'hA5, 0, 0);
        check_state("load_a5", 8'hA5, 0, 1'b0);

        // Right serialise, MSB-first order of SOUT_R is A5's LSB upward
        for (int k = 0; k < 8; k++) begin
            check($sformatf("sout_r_%0d", k), 32'(sout_r), 32'(sr_bits[7-k]));
            step(0, 1, 2'b01, 8'h00, 0, 0);
            if (k < 7) check($sformatf("done_early_%0d", k), 32'(done), 32'(0));
        end
        check_state("ser_end", 8'h00, 8, 1'b1);

        // Left deserialise
        step(0, 1, 2'b11, 8'h00, 0, 0);
        for (int k = 0; k < 8; k++) step(0, 1, 2'b10, 8'h00, 0, sl_bits[7-k]);
        check_state("deser_end", 8'hCB, 8, 1'b1);
        step(0, 1, 2'b10, 8'h00, 0, 1);
        check_state("deser_sat", 8'h97, 8, 1'b1);

        // Enable low freezes a shift; MODE=00 holds
        step(0, 1, 2'b11, 8'h3C, 0, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 2'b01, 8'h00, 1, 1);
            check_state($sformatf("en0_%0d", k), 8'h3C, 0, 1'b0);
        end
        for (int k = 0; k < 2; k++) begin
            step(0, 1, 2'b00, 8'hFF, 1, 1);
            check_state($sformatf("hold_%0d", k), 8'h3C, 0, 1'b0);
        end

        // Reset mid-shift loses the word
        step(0, 1, 2'b11, 8'hF0, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 1, 2'b01, 8'h00, 1, 0);
        check_state("mid_shift", 8'hFE, 3, 1'b0);
        step(1, 1, 2'b01, 8'h00, 1, 0);
        check_state("mid_reset", 8'h00, 0, 1'b0);
        step(0, 1, 2'b11, 8'h81, 0, 0);
        check_state("load_81", 8'h81, 0, 1'b0);

        // Mixed directions both count: 4 right then 4 left
        for (int k = 0; k < 4; k++) step(0, 1, 2'b01, 8'h00, 0, 0);
        check_state("mixed_r", 8'h08, 4, 1'b0);
        for (int k = 0; k < 4; k++) step(0, 1, 2'b10, 8'h00, 0, 1);
        check_state("mixed_l", 8'h8F, 8, 1'b1);

        // Reload immediately after DONE
        step(0, 1, 2'b11, 8'h5A, 0, 0);
        check_state("reload", 8'h5A, 0, 1'b0);

        step(0, 1, 2'b00, 8'h00, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
